clk_ce_gen: RTL

- Synthesizable, parametrised successor to the fixed-ratio PLL wrapper.
- Generates NUM_CH fractional clock-enable pulses and 50%-duty toggle outputs from a single system clock, using phase accumulators.
- Each channel's ratio is runtime-reconfigurable. A lock indication and phase alignment across all channels are provided.
- Sits between the system clock and the subsystems that need slow video, CPU or audio rates, e.g. 9 MHz and 4 MHz from 50 MHz.

---
 rtl/clk_ce_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clk_ce_gen.sv
// Fractional clock-enable generator: one phase accumulator per channel produces
// ce pulses at f_refclk*inc/mod and a toggle output at half that rate.
module clk_ce_gen #(
    parameter int                        NUM_CH        = 3,
    parameter int                        ACC_W         = 16,
    parameter int                        LOCK_CYCLES   = 16,
    parameter logic [NUM_CH*ACC_W-1:0]   DEF_INC       = {16'd4, 16'd9, 16'd50},
    parameter logic [NUM_CH*ACC_W-1:0]   DEF_MOD       = {16'd50, 16'd50, 16'd50},
    parameter bit                        GATE_UNLOCKED = 1'b1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_mod,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [ACC_W-1:0]  mod_q [NUM_CH];
    logic [ACC_W-1:0]  mod_d [NUM_CH];
    logic [ACC_W:0]    sum   [NUM_CH];
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] outclk_q, outclk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q, locked_d;
    logic              wr_hit;
    logic              run;

    // Writes addressed past the last channel are dropped before they reach the lock logic.
    assign wr_hit = cfg_wr && (int'(cfg_ch) < NUM_CH);
    assign run    = GATE_UNLOCKED ? locked_q : 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // The extra bit keeps acc+inc exact even when both are near 2**ACC_W.
            sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            valid[i] = (mod_q[i] != '0) && (inc_q[i] <= mod_q[i]);
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the branches can leave a value unassigned and infer a latch.
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (wr_hit) begin
            cnt_d    = '0;
            locked_d = 1'b0;
        end else if (!locked_q) begin
            if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                locked_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ce_d     = '0;
        outclk_d = outclk_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            inc_d[i] = inc_q[i];
            mod_d[i] = mod_q[i];

            if (GATE_UNLOCKED && (!locked_q || wr_hit)) begin
                // Holding every channel at zero until lock makes all of them restart together.
                acc_d[i]    = '0;
                outclk_d[i] = 1'b0;
            end else if (!valid[i]) begin
                acc_d[i] = '0;
            end else if (run) begin
                if (sum[i] >= {1'b0, mod_q[i]}) begin
                    acc_d[i]    = ACC_W'(sum[i] - {1'b0, mod_q[i]});
                    ce_d[i]     = 1'b1;
                    outclk_d[i] = ~outclk_q[i];
                end else begin
                    acc_d[i] = sum[i][ACC_W-1:0];
                end
            end

            if (wr_hit && (int'(cfg_ch) == i)) begin
                inc_d[i] = cfg_inc;
                mod_d[i] = cfg_mod;
                acc_d[i] = '0;
                ce_d[i]  = 1'b0;
                if (!GATE_UNLOCKED) begin
                    outclk_d[i] = outclk_q[i];
                end
            end
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the values from before the edge, independent of block order.
    always_ff @(posedge refclk) begin
        if (rst) begin
            // NOTE: the per-channel arrays are a handful of flops, not a RAM, so resetting
            // them to their defaults costs nothing and removes any power-up ambiguity.
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= DEF_INC[i*ACC_W +: ACC_W];
                mod_q[i] <= DEF_MOD[i*ACC_W +: ACC_W];
            end
            ce_q     <= '0;
            outclk_q <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
                mod_q[i] <= mod_d[i];
            end
            ce_q     <= ce_d;
            outclk_q <= outclk_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign ce     = ce_q;
    assign outclk = outclk_q;
    assign locked = locked_q;

endmodule
